instr_buffer: RTL and testbench

- Instruction fetch queue between the instruction cache return path and decode.
- Accepts up to two {pc, instr} pairs per cycle from the cache return lanes and presents up to two in-order entries per cycle to decode.
- Back-pressures the fetch stage through full_o, so the cache is stalled before the queue can overflow.
- Flushed on redirect (branch/exception).

---
 rtl/ib_pkg.sv | 23 ++
 rtl/instr_buffer_ram.sv | 33 +++
 rtl/instr_buffer.sv | 146 ++++++++++++++
 tb/tb_instr_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ib_pkg.sv
// rtl/ib_pkg.sv - shared types and sizing for the instruction fetch buffer
package ib_pkg;

    localparam int IB_ADDR_WIDTH = 32;
    localparam int IB_DATA_WIDTH = 32;
    localparam int IB_DEPTH      = 8;
    localparam int IB_PTR_W      = $clog2(IB_DEPTH);

    typedef struct packed {
        logic [IB_ADDR_WIDTH-1:0] pc;
        logic [IB_DATA_WIDTH-1:0] instr;
    } ib_entry_t;

    // Decode may only take lane 2 together with lane 1.
    function automatic logic [1:0] ib_accept_count(input logic [1:0] accept);
        case (accept)
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_buffer_ram.sv
// rtl/instr_buffer_ram.sv - entry storage: two write ports, two asynchronous read ports
module instr_buffer_ram
    import ib_pkg::*;
#(
    parameter int  DEPTH   = IB_DEPTH,
    parameter int  PTR_W   = IB_PTR_W,
    parameter type entry_t = ib_entry_t
) (
    input  logic             clk,
    input  logic             we_0,
    input  logic [PTR_W-1:0] wr_addr_0,
    input  entry_t           wr_data_0,
    input  logic             we_1,
    input  logic [PTR_W-1:0] wr_addr_1,
    input  entry_t           wr_data_1,
    input  logic [PTR_W-1:0] rd_addr_0,
    output entry_t           rd_data_0,
    input  logic [PTR_W-1:0] rd_addr_1,
    output entry_t           rd_data_1
);

    entry_t mem [DEPTH];

    // Write addresses are always consecutive slots, so the ports never collide.
    always_ff @(posedge clk) begin
        if (we_0) mem[wr_addr_0] <= wr_data_0;
        if (we_1) mem[wr_addr_1] <= wr_data_1;
    end

    assign rd_data_0 = mem[rd_addr_0];
    assign rd_data_1 = mem[rd_addr_1];

endmodule

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - dual-lane in-order fetch queue; INSTR_BUFFER_BYPASS_EN adds empty-queue forwarding
module instr_buffer
    import ib_pkg::*;
#(
    parameter int ADDR_WIDTH = IB_ADDR_WIDTH,
    parameter int DATA_WIDTH = IB_DATA_WIDTH,
    parameter int DEPTH      = IB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_valid_1_i,
    input  logic [ADDR_WIDTH-1:0] push_pc_1_i,
    input  logic [DATA_WIDTH-1:0] push_instr_1_i,
    input  logic                  push_valid_2_i,
    input  logic [ADDR_WIDTH-1:0] push_pc_2_i,
    input  logic [DATA_WIDTH-1:0] push_instr_2_i,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  out_valid_1_o,
    output logic [ADDR_WIDTH-1:0] out_pc_1_o,
    output logic [DATA_WIDTH-1:0] out_instr_1_o,
    output logic                  out_valid_2_o,
    output logic [ADDR_WIDTH-1:0] out_pc_2_o,
    output logic [DATA_WIDTH-1:0] out_instr_2_o,
    input  logic [1:0]            accept_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    entry_t     rd_0, rd_1, push_0, push_1, out_0, out_1, wr_0, wr_1;
    logic [1:0] n_push, n_valid, n_pop, stor_pop, skip, n_avail, n_wr;
    logic [CNT_W:0] space;
    logic       bypass, we_0, we_1, drop;

`ifdef INSTR_BUFFER_BYPASS_EN
    assign bypass = (count == '0) && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // Compact the cache lanes so a lone lane-2 push lands in the first slot.
    always_comb begin
        push_0 = '0;
        push_1 = '0;
        n_push = 2'd0;
        if (push_valid_1_i) begin
            push_0 = '{pc: push_pc_1_i, instr: push_instr_1_i};
            if (push_valid_2_i) begin
                push_1 = '{pc: push_pc_2_i, instr: push_instr_2_i};
                n_push = 2'd2;
            end else begin
                n_push = 2'd1;
            end
        end else if (push_valid_2_i) begin
            push_0 = '{pc: push_pc_2_i, instr: push_instr_2_i};
            n_push = 2'd1;
        end
    end

    always_comb begin
        out_0 = rd_0;
        out_1 = rd_1;
        if (flush_i)                     n_valid = 2'd0;
        else if (count >= CNT_W'(2))     n_valid = 2'd2;
        else if (count == CNT_W'(1))     n_valid = 2'd1;
        else                             n_valid = 2'd0;
        if (bypass) begin
            out_0   = push_0;
            out_1   = push_1;
            n_valid = n_push;
        end
    end

    // Pops consume bypassed pushes first when forwarding, otherwise stored entries.
    always_comb begin
        n_pop    = (ib_accept_count(accept_i) > n_valid) ? n_valid : ib_accept_count(accept_i);
        skip     = bypass ? n_pop : 2'd0;
        stor_pop = bypass ? 2'd0 : n_pop;
        n_avail  = n_push - skip;
        space    = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(stor_pop);
        n_wr     = (space >= (CNT_W+1)'(n_avail)) ? n_avail : space[1:0];
        wr_0     = (skip == 2'd0) ? push_0 : push_1;
        wr_1     = push_1;
        we_0     = !flush_i && (n_wr != 2'd0);
        we_1     = !flush_i && (n_wr == 2'd2);
        drop     = !flush_i && (n_avail != n_wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr + PTR_W'(stor_pop);
            wr_ptr     <= wr_ptr + PTR_W'(n_wr);
            count      <= count + CNT_W'(n_wr) - CNT_W'(stor_pop);
            overflow_q <= drop;
        end
    end

    instr_buffer_ram #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .entry_t (entry_t)
    ) u_ram (
        .clk       (clk),
        .we_0      (we_0),
        .wr_addr_0 (wr_ptr),
        .wr_data_0 (wr_0),
        .we_1      (we_1),
        .wr_addr_1 (wr_ptr + PTR_W'(1)),
        .wr_data_1 (wr_1),
        .rd_addr_0 (rd_ptr),
        .rd_data_0 (rd_0),
        .rd_addr_1 (rd_ptr + PTR_W'(1)),
        .rd_data_1 (rd_1)
    );

    assign full_o        = count >= CNT_W'(DEPTH - 1);
    assign overflow_o    = overflow_q;
    assign out_valid_1_o = n_valid != 2'd0;
    assign out_valid_2_o = n_valid == 2'd2;
    assign out_pc_1_o    = out_valid_1_o ? out_0.pc    : '0;
    assign out_instr_1_o = out_valid_1_o ? out_0.instr : '0;
    assign out_pc_2_o    = out_valid_2_o ? out_1.pc    : '0;
    assign out_instr_2_o = out_valid_2_o ? out_1.instr : '0;

endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - self-checking bench for instr_buffer (honours INSTR_BUFFER_BYPASS_EN)
module tb_instr_buffer;

    localparam int DEPTH = 8;
`ifdef INSTR_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        push_valid_1_i, push_valid_2_i;
    logic [31:0] push_pc_1_i, push_instr_1_i, push_pc_2_i, push_instr_2_i;
    logic        full_o, overflow_o;
    logic        out_valid_1_o, out_valid_2_o;
    logic [31:0] out_pc_1_o, out_instr_1_o, out_pc_2_o, out_instr_2_o;
    logic [1:0]  accept_i;

    instr_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .push_valid_1_i (push_valid_1_i),
        .push_pc_1_i    (push_pc_1_i),
        .push_instr_1_i (push_instr_1_i),
        .push_valid_2_i (push_valid_2_i),
        .push_pc_2_i    (push_pc_2_i),
        .push_instr_2_i (push_instr_2_i),
        .full_o         (full_o),
        .overflow_o     (overflow_o),
        .out_valid_1_o  (out_valid_1_o),
        .out_pc_1_o     (out_pc_1_o),
        .out_instr_1_o  (out_instr_1_o),
        .out_valid_2_o  (out_valid_2_o),
        .out_pc_2_o     (out_pc_2_o),
        .out_instr_2_o  (out_instr_2_o),
        .accept_i       (accept_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          v1;
        logic [31:0] p1;
        bit          v2;
        logic [31:0] p2;
        logic [1:0]  acc;
        bit          ev1;
        logic [31:0] epc1;
        bit          ev2;
        logic [31:0] epc2;
        bit          efull;
        bit          eovf;
    } vec_t;

    ent_t        mq[$];
    logic [31:0] pop_log[$];
    bit          m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, compare outputs with the queue model, advance the model.
    task automatic apply(input bit fl, input bit v1, input logic [31:0] p1,
                         input bit v2, input logic [31:0] p2, input logic [1:0] acc);
        ent_t pl[$];
        ent_t lst[$];
        ent_t e;
        int   pops;
        bit   byp;
        flush_i = fl; accept_i = acc;
        push_valid_1_i = v1; push_pc_1_i = p1; push_instr_1_i = ~p1;
        push_valid_2_i = v2; push_pc_2_i = p2; push_instr_2_i = ~p2;
        #2;
        if (v1) begin e.pc = p1; e.instr = ~p1; pl.push_back(e); end
        if (v2) begin e.pc = p2; e.instr = ~p2; pl.push_back(e); end
        byp = BYP && (mq.size() == 0) && !fl;
        if (!fl) begin
            if (byp) lst = pl;
            else for (int k = 0; k < 2 && k < mq.size(); k++) lst.push_back(mq[k]);
        end
        check("m_valid_1", 64'(out_valid_1_o), 64'(lst.size() >= 1));
        check("m_valid_2", 64'(out_valid_2_o), 64'(lst.size() >= 2));
        check("m_lane_1",  {out_pc_1_o, out_instr_1_o}, (lst.size() >= 1) ? lst[0] : 64'd0);
        check("m_lane_2",  {out_pc_2_o, out_instr_2_o}, (lst.size() >= 2) ? lst[1] : 64'd0);
        check("m_full",    64'(full_o), 64'(mq.size() >= DEPTH - 1));
        check("m_overflow", 64'(overflow_o), 64'(m_ovf));
        pops = (acc == 2'b11) ? 2 : (acc == 2'b01) ? 1 : 0;
        if (pops > lst.size()) pops = lst.size();
        for (int k = 0; k < pops; k++) pop_log.push_back(lst[k].pc);
        m_ovf = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            for (int k = 0; k < pops; k++) begin
                if (byp) void'(pl.pop_front());
                else     void'(mq.pop_front());
            end
            while (pl.size() > 0) begin
                if (mq.size() < DEPTH) mq.push_back(pl.pop_front());
                else begin void'(pl.pop_front()); m_ovf = 1'b1; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit fl, input bit v1, input logic [31:0] p1,
                         input bit v2, input logic [31:0] p2, input logic [1:0] acc);
        apply(fl, v1, p1, v2, p2, acc);
        tick();
    endtask

    function automatic vec_t mk(input bit v1, input logic [31:0] p1, input bit v2, input logic [31:0] p2,
                                input logic [1:0] acc, input bit ev1, input logic [31:0] epc1,
                                input bit ev2, input logic [31:0] epc2, input bit efull, input bit eovf);
        vec_t r;
        r.v1 = v1; r.p1 = p1; r.v2 = v2; r.p2 = p2; r.acc = acc;
        r.ev1 = ev1; r.epc1 = epc1; r.ev2 = ev2; r.epc2 = epc2; r.efull = efull; r.eovf = eovf;
        return r;
    endfunction

    vec_t vt[20];

    initial begin
        logic [31:0] pc_ctr;
        int          i_pc;
        bit          v1r, v2r, flr;

        vt[0]  = mk(0, 0,            0, 0,     2'b00, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 32'h1c000000, 0, 0,     2'b00, BYP, BYP ? 32'h1c000000 : 32'h0, 0, 0, 0, 0);
        vt[2]  = mk(0, 0,            0, 0,     2'b00, 1, 32'h1c000000, 0, 0, 0, 0);
        vt[3]  = mk(0, 0,            0, 0,     2'b01, 1, 32'h1c000000, 0, 0, 0, 0);
        vt[4]  = mk(1, 32'h200, 1, 32'h204,    2'b00, BYP, BYP ? 32'h200 : 32'h0,
                    BYP, BYP ? 32'h204 : 32'h0, 0, 0);
        vt[5]  = mk(1, 32'h208, 1, 32'h20c,    2'b00, 1, 32'h200, 1, 32'h204, 0, 0);
        vt[6]  = mk(1, 32'h210, 1, 32'h214,    2'b00, 1, 32'h200, 1, 32'h204, 0, 0);
        vt[7]  = mk(1, 32'h218, 1, 32'h21c,    2'b00, 1, 32'h200, 1, 32'h204, 0, 0);
        vt[8]  = mk(1, 32'h220, 1, 32'h224,    2'b00, 1, 32'h200, 1, 32'h204, 1, 0);
        vt[9]  = mk(0, 0,       0, 0,          2'b00, 1, 32'h200, 1, 32'h204, 1, 1);
        vt[10] = mk(0, 0,       0, 0,          2'b00, 1, 32'h200, 1, 32'h204, 1, 0);
        vt[11] = mk(1, 32'h230, 1, 32'h234,    2'b11, 1, 32'h200, 1, 32'h204, 1, 0);
        vt[12] = mk(0, 0,       0, 0,          2'b00, 1, 32'h208, 1, 32'h20c, 1, 0);
        vt[13] = mk(0, 0,       0, 0,          2'b01, 1, 32'h208, 1, 32'h20c, 1, 0);
        vt[14] = mk(0, 0,       0, 0,          2'b00, 1, 32'h20c, 1, 32'h210, 1, 0);
        vt[15] = mk(0, 0,       0, 0,          2'b11, 1, 32'h20c, 1, 32'h210, 1, 0);
        vt[16] = mk(0, 0,       0, 0,          2'b11, 1, 32'h214, 1, 32'h218, 0, 0);
        vt[17] = mk(0, 0,       0, 0,          2'b11, 1, 32'h21c, 1, 32'h230, 0, 0);
        vt[18] = mk(0, 0,       0, 0,          2'b11, 1, 32'h234, 0, 32'h0,   0, 0);
        vt[19] = mk(0, 0,       0, 0,          2'b00, 0, 32'h0,   0, 32'h0,   0, 0);

        rst_n = 1'b0; flush_i = 1'b0; accept_i = 2'b00;
        push_valid_1_i = 1'b0; push_pc_1_i = '0; push_instr_1_i = '0;
        push_valid_2_i = 1'b0; push_pc_2_i = '0; push_instr_2_i = '0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_1", 64'(out_valid_1_o), 64'd0);
        check("rst_valid_2", 64'(out_valid_2_o), 64'd0);
        check("rst_full",    64'(full_o),        64'd0);
        check("rst_overflow", 64'(overflow_o),   64'd0);
        check("rst_pc_1",    64'(out_pc_1_o),    64'd0);
        rst_n = 1'b1;
        tick();

        // Table: first push, fill to full, overflow, pop+push at full, drain.
        for (int r = 0; r < 20; r++) begin
            apply(1'b0, vt[r].v1, vt[r].p1, vt[r].v2, vt[r].p2, vt[r].acc);
            check($sformatf("t%0d_valid_1", r), 64'(out_valid_1_o), 64'(vt[r].ev1));
            check($sformatf("t%0d_pc_1", r),    64'(out_pc_1_o),    64'(vt[r].epc1));
            check($sformatf("t%0d_valid_2", r), 64'(out_valid_2_o), 64'(vt[r].ev2));
            check($sformatf("t%0d_pc_2", r),    64'(out_pc_2_o),    64'(vt[r].epc2));
            check($sformatf("t%0d_full", r),    64'(full_o),        64'(vt[r].efull));
            check($sformatf("t%0d_overflow", r), 64'(overflow_o),   64'(vt[r].eovf));
            tick();
        end

        // Pointer wrap: 11 single pushes with pop-1 each cycle, then drain.
        pop_log.delete();
        for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, 32'(4 * i), 1'b0, 0, 2'b01);
        repeat (2) cycle(1'b0, 1'b0, 0, 1'b0, 0, 2'b01);
        check("wrap_pop_count", 64'(pop_log.size()), 64'd11);
        for (int i = 0; i < pop_log.size(); i++)
            check($sformatf("wrap_pc_%0d", i), 64'(pop_log[i]), 64'(4 * i));

        // Flush at count 5 with a simultaneous push and accept.
        cycle(1'b0, 1'b1, 32'h500, 1'b1, 32'h504, 2'b00);
        cycle(1'b0, 1'b1, 32'h508, 1'b1, 32'h50c, 2'b00);
        cycle(1'b0, 1'b0, 0,       1'b1, 32'h510, 2'b00);
        check("pre_flush_full", 64'(full_o), 64'd0);
        apply(1'b1, 1'b1, 32'h900, 1'b1, 32'h904, 2'b11);
        check("flush_valid_1", 64'(out_valid_1_o), 64'd0);
        check("flush_valid_2", 64'(out_valid_2_o), 64'd0);
        tick();
        apply(1'b0, 1'b0, 0, 1'b0, 0, 2'b00);
        check("post_flush_valid_1", 64'(out_valid_1_o), 64'd0);
        check("post_flush_overflow", 64'(overflow_o), 64'd0);
        tick();

        // Bypass: empty queue, lane-1 push accepted in the same cycle.
        apply(1'b0, 1'b1, 32'h100, 1'b0, 0, 2'b01);
        check("byp_same_valid_1", 64'(out_valid_1_o), 64'(BYP));
        tick();
        apply(1'b0, 1'b0, 0, 1'b0, 0, 2'b01);
        check("byp_next_valid_1", 64'(out_valid_1_o), 64'(!BYP));
        tick();

        // Lone lane-2 pushes.
        cycle(1'b0, 1'b0, 0, 1'b1, 32'h600, 2'b00);
        cycle(1'b0, 1'b0, 0, 1'b1, 32'h604, 2'b00);
        repeat (2) cycle(1'b0, 1'b0, 0, 1'b0, 0, 2'b11);

        // Randomised traffic against the model; flush is rare.
        pc_ctr = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            v1r = ($urandom_range(0, 3) != 0);
            v2r = ($urandom_range(0, 2) != 0);
            flr = ($urandom_range(0, 39) == 0);
            i_pc = $urandom_range(0, 3);
            cycle(flr, v1r, pc_ctr, v2r, pc_ctr + 4, 2'(i_pc));
            pc_ctr = pc_ctr + 8;
        end

        // Asynchronous reset mid-operation.
        cycle(1'b0, 1'b1, 32'h700, 1'b1, 32'h704, 2'b00);
        cycle(1'b0, 1'b1, 32'h708, 1'b0, 0,       2'b00);
        flush_i = 1'b0; accept_i = 2'b00; push_valid_1_i = 1'b0; push_valid_2_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid_1", 64'(out_valid_1_o), 64'd0);
        check("arst_pc_1",    64'(out_pc_1_o),    64'd0);
        check("arst_full",    64'(full_o),        64'd0);
        check("arst_overflow", 64'(overflow_o),   64'd0);
        mq.delete();
        m_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 0, 1'b0, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
